// File: rtl/data_mem_arb_pkg.sv
// Shared types and constants for the data memory arbiter.
package data_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  localparam int unsigned PORT_CORE = 0;
  localparam int unsigned PORT_AUX  = 1;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;

endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the
// port that was not granted last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  // Tie-break toward the port that did not win last time.
  always_comb begin
    gnt = '0;
    if (req == 2'b11) begin
      gnt = last_grant ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-port data memory between the core (port 0) and an
// auxiliary master (port 1), with round-robin fairness, registered read
// return and a time-bounded bus lock for read-modify-write sequences.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int unsigned LOCK_LIMIT = 16
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p1_req,
  input  logic              p0_we,
  input  logic              p1_we,
  input  logic              p0_lock,
  input  logic              p1_lock,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p0_gnt,
  output logic              p1_gnt,
  output logic              p0_rvalid,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              lock_timeout,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = (LOCK_LIMIT > 1) ? $clog2(LOCK_LIMIT) : 1;

  arb_state_t       state, state_next;
  logic [CNT_W-1:0] lock_cnt, lock_cnt_next;
  logic             last_grant, last_grant_next;
  logic             timeout_next;
  logic [1:0]       rr_gnt;
  logic [1:0]       gnt;

  rr_arb2 u_rr (
    .req        ({p1_req, p0_req}),
    .last_grant (last_grant),
    .gnt        (rr_gnt)
  );

  // Grant selection: round-robin when free, owner-only while locked,
  // nothing while reset is asserted.
  always_comb begin
    gnt = '0;
    if (!reset) begin
      unique case (state)
        IDLE:    gnt = rr_gnt;
        LOCK0:   gnt[PORT_CORE] = p0_req;
        LOCK1:   gnt[PORT_AUX]  = p1_req;
        default: gnt = '0;
      endcase
    end
  end

  assign p0_gnt = gnt[PORT_CORE];
  assign p1_gnt = gnt[PORT_AUX];

  // Steer the granted port onto the memory bus; idle bus is all zeros.
  always_comb begin
    mem_addr     = '0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    mem_wdata    = '0;
    if (gnt[PORT_CORE]) begin
      mem_addr     = p0_addr;
      mem_read_en  = !p0_we;
      mem_write_en = p0_we;
      mem_wdata    = p0_we ? p0_wdata : '0;
    end else if (gnt[PORT_AUX]) begin
      mem_addr     = p1_addr;
      mem_read_en  = !p1_we;
      mem_write_en = p1_we;
      mem_wdata    = p1_we ? p1_wdata : '0;
    end
  end

  // Lock FSM, lock age counter and round-robin history.
  always_comb begin
    state_next      = state;
    lock_cnt_next   = lock_cnt;
    timeout_next    = 1'b0;
    last_grant_next = last_grant;
    if (gnt[PORT_CORE]) begin
      last_grant_next = 1'b0;
    end else if (gnt[PORT_AUX]) begin
      last_grant_next = 1'b1;
    end
    unique case (state)
      IDLE: begin
        lock_cnt_next = '0;
        if (gnt[PORT_CORE] && p0_lock) begin
          state_next = LOCK0;
        end else if (gnt[PORT_AUX] && p1_lock) begin
          state_next = LOCK1;
        end
      end
      LOCK0: begin
        // A voluntary release on the limit cycle wins over the timeout.
        if (!p0_lock) begin
          state_next    = IDLE;
          lock_cnt_next = '0;
        end else if (lock_cnt == CNT_W'(LOCK_LIMIT - 1)) begin
          state_next      = IDLE;
          lock_cnt_next   = '0;
          timeout_next    = 1'b1;
          last_grant_next = 1'b0;
        end else begin
          lock_cnt_next = lock_cnt + CNT_W'(1);
        end
      end
      LOCK1: begin
        if (!p1_lock) begin
          state_next    = IDLE;
          lock_cnt_next = '0;
        end else if (lock_cnt == CNT_W'(LOCK_LIMIT - 1)) begin
          state_next      = IDLE;
          lock_cnt_next   = '0;
          timeout_next    = 1'b1;
          last_grant_next = 1'b1;
        end else begin
          lock_cnt_next = lock_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next    = IDLE;
        lock_cnt_next = '0;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state        <= IDLE;
      lock_cnt     <= '0;
      last_grant   <= 1'b1;
      lock_timeout <= 1'b0;
    end else begin
      state        <= state_next;
      lock_cnt     <= lock_cnt_next;
      last_grant   <= last_grant_next;
      lock_timeout <= timeout_next;
    end
  end

  // Read return: capture memory data only on a granted read.
  always_ff @(posedge CLK) begin
    if (reset) begin
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      p0_rvalid <= gnt[PORT_CORE] && !p0_we;
      p1_rvalid <= gnt[PORT_AUX] && !p1_we;
      if (gnt[PORT_CORE] && !p0_we) begin
        p0_rdata <= mem_rdata;
      end
      if (gnt[PORT_AUX] && !p1_we) begin
        p1_rdata <= mem_rdata;
      end
    end
  end

endmodule
